// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit hex seven-segment driver; optional leading-zero blanking under BLANK_LEADING_ZERO_EN.
// Latency: an/seg/dp registered one cycle after the digit index; frame_done one cycle after the boundary.
// Backpressure: none; load is always accepted, busy flags a value waiting for the next frame boundary.
module seg7_scan_driver #(
   parameter int PRESCALE       = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        load,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done,
   output logic        busy
);

   localparam int             CW      = $clog2(PRESCALE);
   localparam logic [CW-1:0]  CNT_MAX = CW'(PRESCALE - 1);
   localparam logic [3:0]     AN_INV  = AN_ACTIVE_LOW ? 4'hF : 4'h0;
   localparam logic [6:0]     SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic           DP_INV  = SEG_ACTIVE_LOW;

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   shadow_val;
   logic [3:0]    shadow_dp;
   logic [15:0]   pend_val;
   logic [3:0]    pend_dp;
   logic          tick;
   logic          boundary;
   logic          commit_now;
   logic [3:0]    blank;
   logic [3:0]    nib;
   logic [3:0]    an_nx;
   logic [6:0]    seg_nx;
   logic          dp_nx;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      s = 7'h00;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         4'hF: s = 7'h71;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   assign tick     = enable && (cnt == CNT_MAX);
   assign boundary = tick && (idx == 2'd3);
   // With scanning stopped there is no frame to tear, so commits happen immediately.
   assign commit_now = boundary || !enable;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt        <= '0;
         idx        <= 2'd0;
         frame_done <= 1'b0;
      end else if (!enable) begin
         cnt        <= '0;
         idx        <= 2'd0;
         frame_done <= 1'b0;
      end else begin
         cnt        <= tick ? '0 : cnt + CW'(1);
         idx        <= tick ? idx + 2'd1 : idx;
         frame_done <= boundary;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_val <= '0;
         shadow_dp  <= '0;
         pend_val   <= '0;
         pend_dp    <= '0;
         busy       <= 1'b0;
      end else if (load && commit_now) begin
         shadow_val <= value;
         shadow_dp  <= dp_in;
         busy       <= 1'b0;
      end else if (load) begin
         pend_val <= value;
         pend_dp  <= dp_in;
         busy     <= 1'b1;
      end else if (busy && commit_now) begin
         shadow_val <= pend_val;
         shadow_dp  <= pend_dp;
         busy       <= 1'b0;
      end
   end

`ifdef BLANK_LEADING_ZERO_EN
   always_comb begin
      blank    = 4'b0000;
      blank[3] = (shadow_val[15:12] == 4'h0);
      blank[2] = (shadow_val[15:8] == 8'h00);
      blank[1] = (shadow_val[15:4] == 12'h000);
   end
`else
   always_comb begin
      blank = 4'b0000;
   end
`endif

   assign nib = shadow_val[{idx, 2'b00} +: 4];

   always_comb begin
      an_nx  = 4'b0000;
      seg_nx = 7'h00;
      dp_nx  = 1'b0;
      if (enable) begin
         an_nx = 4'b0001 << idx;
         if (!blank[idx]) begin
            seg_nx = hex7(nib);
            dp_nx  = shadow_dp[idx];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an  <= AN_INV;
         seg <= SEG_INV;
         dp  <= DP_INV;
      end else begin
         an  <= an_nx ^ AN_INV;
         seg <= seg_nx ^ SEG_INV;
         dp  <= dp_nx ^ DP_INV;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at PRESCALE=4 with active-low pins.
module tb_seg7_scan_driver;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;
   logic        busy;

   int checks = 0;
   int errors = 0;

   seg7_scan_driver #(
      .PRESCALE       (4),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .load       (load),
      .value      (value),
      .dp_in      (dp_in),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_done (frame_done),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_fd(input string tag, input int bound);
      int n;
      n = 0;
      do begin
         step(1);
         n++;
      end while (!frame_done && n < bound);
      chk(tag, {15'd0, frame_done}, 16'd1);
   endtask

   // Called on the cycle frame_done is seen; walks one full frame and ends on the next frame_done.
   task automatic frame_check(input string tag, input logic [27:0] exp_seg, input logic [3:0] exp_dp);
      logic [3:0] ea;
      logic [6:0] es;
      int d;
      for (int n = 1; n <= 16; n++) begin
         step(1);
         if (n == 1) chk({tag, "_fd_low"}, {15'd0, frame_done}, 16'd0);
         if ((n - 1) % 4 == 0) begin
            d  = (n - 1) / 4;
            ea = ~(4'b0001 << d);
            es = ~exp_seg[d*7 +: 7];
            chk({tag, "_an"}, {12'd0, an}, {12'd0, ea});
            chk({tag, "_seg"}, {9'd0, seg}, {9'd0, es});
            chk({tag, "_dp"}, {15'd0, dp}, {15'd0, ~exp_dp[d]});
         end
         if (n == 16) chk({tag, "_fd_period"}, {15'd0, frame_done}, 16'd1);
      end
   endtask

   logic [6:0] exp_hi_seg;
   logic       exp_hi_dp;

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      load   = 1'b0;
      value  = 16'h0000;
      dp_in  = 4'h0;

      // Async reset takes effect without a clock edge
      #3 reset = 1'b0;
      #1;
      chk("rst_an", {12'd0, an}, 16'h000F);
      chk("rst_seg", {9'd0, seg}, 16'h007F);
      chk("rst_dp", {15'd0, dp}, 16'd1);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_fd", {15'd0, frame_done}, 16'd0);
      step(1);

      // Load while idle, then show the following frame
      reset  = 1'b1;
      enable = 1'b1;
      load   = 1'b1;
      value  = 16'h12AF;
      dp_in  = 4'h0;
      step(1);
      load = 1'b0;
      chk("t2_busy_set", {15'd0, busy}, 16'd1);
      chk("t2_fd_low", {15'd0, frame_done}, 16'd0);
      wait_fd("t2_fd_wait", 40);
      chk("t2_busy_clr", {15'd0, busy}, 16'd0);
      frame_check("t2", {7'h06, 7'h5B, 7'h77, 7'h71}, 4'h0);

      // Two loads in one frame: the later one wins
      load  = 1'b1;
      value = 16'h1111;
      step(1);
      load = 1'b0;
      chk("t3_busy", {15'd0, busy}, 16'd1);
      step(2);
      load  = 1'b1;
      value = 16'h2222;
      step(1);
      load = 1'b0;
      wait_fd("t3_fd_wait", 40);
      frame_check("t3", {4{7'h5B}}, 4'h0);

      // Load on the exact boundary cycle commits directly
      step(15);
      load  = 1'b1;
      value = 16'h3333;
      step(1);
      load = 1'b0;
      chk("t4_fd", {15'd0, frame_done}, 16'd1);
      chk("t4_busy", {15'd0, busy}, 16'd0);
      frame_check("t4", {4{7'h4F}}, 4'h0);

      // Disable mid-frame, load while dark, re-enable
      step(5);
      enable = 1'b0;
      step(1);
      chk("t5_an_dark", {12'd0, an}, 16'h000F);
      chk("t5_seg_dark", {9'd0, seg}, 16'h007F);
      chk("t5_dp_dark", {15'd0, dp}, 16'd1);
      chk("t5_fd", {15'd0, frame_done}, 16'd0);
      load  = 1'b1;
      value = 16'h0505;
      step(1);
      load   = 1'b0;
      enable = 1'b1;
      chk("t5_busy", {15'd0, busy}, 16'd0);
      step(1);
      chk("t5_d0_an", {12'd0, an}, 16'h000E);
      chk("t5_d0_seg", {9'd0, seg}, 16'h0012);
      step(3);
      chk("t5_d0_hold", {12'd0, an}, 16'h000E);
      step(1);
      chk("t5_d1_an", {12'd0, an}, 16'h000D);
      chk("t5_d1_seg", {9'd0, seg}, 16'h0040);

      // Leading zeros and decimal points
`ifdef BLANK_LEADING_ZERO_EN
      exp_hi_seg = 7'h7F;
      exp_hi_dp  = 1'b1;
`else
      exp_hi_seg = 7'h40;
      exp_hi_dp  = 1'b0;
`endif
      enable = 1'b0;
      step(1);
      load  = 1'b1;
      value = 16'h0050;
      dp_in = 4'b0110;
      step(1);
      load   = 1'b0;
      enable = 1'b1;
      step(1);
      chk("t6_d0_an", {12'd0, an}, 16'h000E);
      chk("t6_d0_seg", {9'd0, seg}, 16'h0040);
      chk("t6_d0_dp", {15'd0, dp}, 16'd1);
      step(4);
      chk("t6_d1_an", {12'd0, an}, 16'h000D);
      chk("t6_d1_seg", {9'd0, seg}, 16'h0012);
      chk("t6_d1_dp", {15'd0, dp}, 16'd0);
      step(4);
      chk("t6_d2_an", {12'd0, an}, 16'h000B);
      chk("t6_d2_seg", {9'd0, seg}, {9'd0, exp_hi_seg});
      chk("t6_d2_dp", {15'd0, dp}, {15'd0, exp_hi_dp});
      step(4);
      chk("t6_d3_an", {12'd0, an}, 16'h0007);
      chk("t6_d3_seg", {9'd0, seg}, {9'd0, exp_hi_seg});
      chk("t6_d3_dp", {15'd0, dp}, 16'd1);

      // Reset mid-frame discards pending and displayed values
      load  = 1'b1;
      value = 16'h1234;
      dp_in = 4'h0;
      step(1);
      load = 1'b0;
      chk("rm_busy_set", {15'd0, busy}, 16'd1);
      #2 reset = 1'b0;
      #1;
      chk("rm_an", {12'd0, an}, 16'h000F);
      chk("rm_busy", {15'd0, busy}, 16'd0);
      #1 reset = 1'b1;
      step(1);
      chk("rm_restart_an", {12'd0, an}, 16'h000E);
      chk("rm_restart_seg", {9'd0, seg}, 16'h0040);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
